// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 receiver slice.
//   PS2_EXT / PS2_BRK : scancode prefix bytes (extended, break)
//   DATA_W            : FIFO entry width, 10 with PS2_SCANCODE_DECODE_EN
//                       ({ext, brk, code[7:0]}), 8 otherwise (raw byte)
//   rx_state_e        : receiver frame state
//   odd_parity_ok()   : true when data bits plus parity bit hold an odd
//                       number of ones
// Configuration macro: PS2_SCANCODE_DECODE_EN
// ----------------------------------------------------------------------------
package ps2_pkg;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

`ifdef PS2_SCANCODE_DECODE_EN
   localparam int unsigned DATA_W = 10;
`else
   localparam int unsigned DATA_W = 8;
`endif

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } rx_state_e;

   function automatic logic odd_parity_ok(input logic [7:0] b, input logic p);
      return ^{b, p};
   endfunction

endpackage

// File: rtl/ps2_rx_fifo_sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock show-ahead FIFO. The head entry is presented combinationally
// from registered storage; pops on an empty FIFO are ignored, pushes on a
// full FIFO are dropped unless a pop happens on the same edge.
// Ports:
//   clk_i      : clock
//   rst_i      : synchronous active-high reset (clears storage and pointers)
//   push_i     : write request
//   wdata_i    : write data [WIDTH]
//   pop_i      : remove head entry
//   rdata_o    : head entry [WIDTH], valid while !empty_o
//   empty_o    : no entries held
//   count_o    : occupancy [$clog2(DEPTH)+1]
//   overflow_o : one-cycle pulse after a push was dropped
// DEPTH must be a power of two, at least 2.
// ----------------------------------------------------------------------------
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     overflow_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             overflow_q;

   logic             full;
   logic             do_push;
   logic             do_pop;

   always_comb begin
      empty_o = (count_q == '0);
      full    = (count_q == FULL_CNT);
      do_pop  = pop_i && !empty_o;
      // a pop on the same edge frees the slot the push needs
      do_push = push_i && (!full || do_pop);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= push_i && !do_push;
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign rdata_o    = mem_q[rd_ptr_q];
   assign count_o    = count_q;
   assign overflow_o = overflow_q;

endmodule

// File: rtl/ps2_rx_fifo.sv
// ----------------------------------------------------------------------------
// ps2_rx_fifo
// PS/2 keyboard receiver: synchronises PS2_CLK/PS2_DATA, deglitches the
// clock, deserialises 11-bit frames (start, 8 data LSB first, odd parity,
// stop), and pushes accepted bytes into a show-ahead FIFO read by the CPU.
// Ports:
//   inCLK_50MHZ : system clock
//   reset       : synchronous active-high reset
//   PS2_CLK     : raw PS/2 clock (asynchronous)
//   PS2_DATA    : raw PS/2 data (asynchronous)
//   rd_en       : pop head entry, ignored when empty
//   rd_data     : head entry [DATA_W], valid while !empty
//   empty       : FIFO empty
//   count       : FIFO occupancy [$clog2(FIFO_DEPTH)+1]
//   rx_busy     : frame in progress
//   err_parity  : one-cycle pulse on parity failure
//   err_frame   : one-cycle pulse on bad stop bit or frame timeout
//   overflow    : one-cycle pulse when a byte is dropped on a full FIFO
// Configuration macro: PS2_SCANCODE_DECODE_EN (entries become
// {ext, brk, code}; E0/F0 prefixes are folded into flags, not pushed).
// ----------------------------------------------------------------------------
module ps2_rx_fifo
   import ps2_pkg::*;
#(
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 50000,
   parameter int unsigned FIFO_DEPTH     = 16
) (
   input  logic                          inCLK_50MHZ,
   input  logic                          reset,
   input  logic                          PS2_CLK,
   input  logic                          PS2_DATA,
   input  logic                          rd_en,
   output logic [DATA_W-1:0]             rd_data,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          rx_busy,
   output logic                          err_parity,
   output logic                          err_frame,
   output logic                          overflow
);

   localparam int unsigned FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   // ---------------------------------------------------------------------
   // Input synchronisers and clock deglitch filter
   // ---------------------------------------------------------------------
   logic           clk_s1_q, clk_s2_q;
   logic           dat_s1_q, dat_s2_q;
   logic           filt_q, filt_d;
   logic           filt_prev_q;
   logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
   logic           fall;

   always_ff @(posedge inCLK_50MHZ) begin
      if (reset) begin
         clk_s1_q <= 1'b1;
         clk_s2_q <= 1'b1;
         dat_s1_q <= 1'b1;
         dat_s2_q <= 1'b1;
      end else begin
         clk_s1_q <= PS2_CLK;
         clk_s2_q <= clk_s1_q;
         dat_s1_q <= PS2_DATA;
         dat_s2_q <= dat_s1_q;
      end
   end

   // Counts consecutive samples that disagree with the filtered level; any
   // agreeing sample restarts the run, so short glitches never flip it.
   always_comb begin
      filt_d     = filt_q;
      filt_cnt_d = '0;
      if (clk_s2_q != filt_q) begin
         if (filt_cnt_q == FILT_LAST) begin
            filt_d = clk_s2_q;
         end else begin
            filt_cnt_d = filt_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge inCLK_50MHZ) begin
      if (reset) begin
         filt_q      <= 1'b1;
         filt_prev_q <= 1'b1;
         filt_cnt_q  <= '0;
      end else begin
         filt_q      <= filt_d;
         filt_prev_q <= filt_q;
         filt_cnt_q  <= filt_cnt_d;
      end
   end

   assign fall = filt_prev_q && !filt_q;

   // ---------------------------------------------------------------------
   // Frame receiver
   // ---------------------------------------------------------------------
   rx_state_e         state_q;
   logic [2:0]        bit_idx_q;
   logic [7:0]        shift_q;
   logic              par_q;
   logic [TW-1:0]     to_cnt_q;
   logic              push_q;
   logic [DATA_W-1:0] push_data_q;
   logic              err_parity_q;
   logic              err_frame_q;
`ifdef PS2_SCANCODE_DECODE_EN
   logic              ext_q;
   logic              brk_q;
`endif

   always_ff @(posedge inCLK_50MHZ) begin
      if (reset) begin
         state_q      <= IDLE;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         par_q        <= 1'b0;
         to_cnt_q     <= '0;
         push_q       <= 1'b0;
         push_data_q  <= '0;
         err_parity_q <= 1'b0;
         err_frame_q  <= 1'b0;
`ifdef PS2_SCANCODE_DECODE_EN
         ext_q        <= 1'b0;
         brk_q        <= 1'b0;
`endif
      end else begin
         push_q       <= 1'b0;
         err_parity_q <= 1'b0;
         err_frame_q  <= 1'b0;

         if (state_q == IDLE || fall) begin
            to_cnt_q <= '0;
         end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
         end

         // a fall on the same cycle counts as activity, so it wins over timeout
         if (state_q != IDLE && !fall && to_cnt_q == TO_LAST) begin
            state_q     <= IDLE;
            err_frame_q <= 1'b1;
`ifdef PS2_SCANCODE_DECODE_EN
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
`endif
         end else if (fall) begin
            case (state_q)
               IDLE: begin
                  if (!dat_s2_q) begin
                     state_q   <= DATA;
                     bit_idx_q <= '0;
                  end
               end
               DATA: begin
                  shift_q <= {dat_s2_q, shift_q[7:1]};
                  if (bit_idx_q == 3'd7) begin
                     state_q <= PARITY;
                  end else begin
                     bit_idx_q <= bit_idx_q + 1'b1;
                  end
               end
               PARITY: begin
                  par_q   <= dat_s2_q;
                  state_q <= STOP;
               end
               STOP: begin
                  state_q <= IDLE;
                  if (!dat_s2_q) begin
                     err_frame_q <= 1'b1;
                  end
                  if (!odd_parity_ok(shift_q, par_q)) begin
                     err_parity_q <= 1'b1;
                  end
                  if (dat_s2_q && odd_parity_ok(shift_q, par_q)) begin
`ifdef PS2_SCANCODE_DECODE_EN
                     if (shift_q == PS2_EXT) begin
                        ext_q <= 1'b1;
                     end else if (shift_q == PS2_BRK) begin
                        brk_q <= 1'b1;
                     end else begin
                        push_q      <= 1'b1;
                        push_data_q <= {ext_q, brk_q, shift_q};
                        ext_q       <= 1'b0;
                        brk_q       <= 1'b0;
                     end
`else
                     push_q      <= 1'b1;
                     push_data_q <= shift_q;
`endif
                  end else begin
`ifdef PS2_SCANCODE_DECODE_EN
                     ext_q <= 1'b0;
                     brk_q <= 1'b0;
`endif
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign rx_busy    = (state_q != IDLE);
   assign err_parity = err_parity_q;
   assign err_frame  = err_frame_q;

   // ---------------------------------------------------------------------
   // Scancode FIFO
   // ---------------------------------------------------------------------
   sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i      (inCLK_50MHZ),
      .rst_i      (reset),
      .push_i     (push_q),
      .wdata_i    (push_data_q),
      .pop_i      (rd_en),
      .rdata_o    (rd_data),
      .empty_o    (empty),
      .count_o    (count),
      .overflow_o (overflow)
   );

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// ----------------------------------------------------------------------------
// tb_ps2_rx_fifo
// Scoreboard bench: the stimulus side drives PS/2 frames and pushes the
// expected FIFO entries / error pulses into a reference model; a separate
// monitor pops the FIFO and compares each presented entry.
// ----------------------------------------------------------------------------
module tb_ps2_rx_fifo;
   import ps2_pkg::DATA_W;

   localparam int unsigned FILTER_LEN     = 8;
   localparam int unsigned TIMEOUT_CYCLES = 300;
   localparam int unsigned FIFO_DEPTH     = 4;
   localparam int unsigned HALF           = 30;
   localparam int unsigned CW             = $clog2(FIFO_DEPTH) + 1;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              ps2_clk = 1'b1;
   logic              ps2_dat = 1'b1;
   logic              rd_en = 1'b0;
   logic [DATA_W-1:0] rd_data;
   logic              empty;
   logic [CW-1:0]     count;
   logic              rx_busy;
   logic              err_parity;
   logic              err_frame;
   logic              overflow;

   always #5 clk = ~clk;

   ps2_rx_fifo #(
      .FILTER_LEN     (FILTER_LEN),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .FIFO_DEPTH     (FIFO_DEPTH)
   ) dut (
      .inCLK_50MHZ (clk),
      .reset       (reset),
      .PS2_CLK     (ps2_clk),
      .PS2_DATA    (ps2_dat),
      .rd_en       (rd_en),
      .rd_data     (rd_data),
      .empty       (empty),
      .count       (count),
      .rx_busy     (rx_busy),
      .err_parity  (err_parity),
      .err_frame   (err_frame),
      .overflow    (overflow)
   );

   int total = 0;
   int bad   = 0;
   int mon_par = 0, mon_frm = 0, mon_ovf = 0;
   int exp_par = 0, exp_frm = 0, exp_ovf = 0;
   logic [DATA_W-1:0] exp_q[$];
   bit drain_en = 1'b0;
   bit pop_end  = 1'b0;
   bit mon_on   = 1'b0;
   bit busy_prev = 1'b0;
   bit ext_p = 1'b0, brk_p = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- monitor: pulse counting and FIFO draining -------------
   initial begin
      forever begin
         @(negedge clk);
         if (mon_on) begin
            bit pop_now;
            if (err_parity) mon_par++;
            if (err_frame)  mon_frm++;
            if (overflow)   mon_ovf++;
            pop_now = !empty && (drain_en || (pop_end && busy_prev && !rx_busy));
            busy_prev = rx_busy;
            if (pop_now) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_entry: got %0h expected none", rd_data);
               end else begin
                  logic [DATA_W-1:0] e;
                  e = exp_q.pop_front();
                  chk("rd_data", 32'(rd_data), 32'(e));
               end
               rd_en = 1'b1;
            end else begin
               rd_en = 1'b0;
            end
         end
      end
   end

   // ---------------- reference model --------------------------------------
   task automatic model_push(input logic [DATA_W-1:0] e, input bit pop_conc);
      if (exp_q.size() >= FIFO_DEPTH && !pop_conc) exp_ovf++;
      else exp_q.push_back(e);
   endtask

   task automatic model_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit pop_conc);
      if (bad_par)  exp_par++;
      if (bad_stop) exp_frm++;
      if (bad_par || bad_stop) begin
         ext_p = 1'b0;
         brk_p = 1'b0;
      end else begin
`ifdef PS2_SCANCODE_DECODE_EN
         if (b == 8'hE0) ext_p = 1'b1;
         else if (b == 8'hF0) brk_p = 1'b1;
         else begin
            model_push({ext_p, brk_p, b}, pop_conc);
            ext_p = 1'b0;
            brk_p = 1'b0;
         end
`else
         model_push(b, pop_conc);
`endif
      end
   endtask

   // ---------------- stimulus ---------------------------------------------
   task automatic send_bits(input logic [10:0] fr, input int n, input int g);
      for (int i = 0; i < n; i++) begin
         ps2_dat = fr[i];
         if (i == g) begin
            repeat (16) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (2) @(posedge clk);
            ps2_clk = 1'b1;
            repeat (HALF - 18) @(posedge clk);
         end else begin
            repeat (HALF) @(posedge clk);
         end
         ps2_clk = 1'b0;
         repeat (HALF) @(posedge clk);
         ps2_clk = 1'b1;
      end
   endtask

   function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      logic p;
      p = (~^b) ^ bad_par;
      return {~bad_stop, p, b, 1'b0};
   endfunction

   task automatic check_status(input string tag);
      @(negedge clk);
      chk({tag, "_err_parity_cnt"}, 32'(mon_par), 32'(exp_par));
      chk({tag, "_err_frame_cnt"},  32'(mon_frm), 32'(exp_frm));
      chk({tag, "_overflow_cnt"},   32'(mon_ovf), 32'(exp_ovf));
      chk({tag, "_rx_busy"},        32'(rx_busy), 32'd0);
      chk({tag, "_count"},          32'(count),   32'(exp_q.size()));
      chk({tag, "_empty"},          32'(empty),   32'(exp_q.size() == 0));
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input int g, input bit pop_conc, input string tag);
      model_frame(b, bad_par, bad_stop, pop_conc);
      pop_end = pop_conc;
      send_bits(mk_frame(b, bad_par, bad_stop), 11, g);
      repeat (HALF) @(posedge clk);
      pop_end = 1'b0;
      check_status(tag);
   endtask

   task automatic idle_glitch();
      repeat (5) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (2) @(posedge clk);
      ps2_clk = 1'b1;
      repeat (HALF) @(posedge clk);
   endtask

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      @(negedge clk);
      chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      repeat (5) @(posedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_empty",   32'(empty),      32'd1);
      chk("rst_count",   32'(count),      32'd0);
      chk("rst_rd_data", 32'(rd_data),    32'd0);
      chk("rst_rx_busy", 32'(rx_busy),    32'd0);
      chk("rst_pulses",  32'({err_parity, err_frame, overflow}), 32'd0);
      mon_on = 1'b1;

      // valid frame, held without reading, then drained
      send_frame(8'h1C, 1'b0, 1'b0, -1, 1'b0, "valid");
      drain_en = 1'b1;
      wait_drain("valid");

      // parity error
      send_frame(8'h1C, 1'b1, 1'b0, -1, 1'b0, "parity");
      // bad stop, then both errors together
      send_frame(8'h5A, 1'b0, 1'b1, -1, 1'b0, "stop");
      send_frame(8'h5A, 1'b1, 1'b1, -1, 1'b0, "both");

      // timeout after start + 3 data bits, then a clean frame
      send_bits(mk_frame(8'h32, 1'b0, 1'b0), 4, -1);
      repeat (TIMEOUT_CYCLES + 10) @(posedge clk);
      exp_frm++;
      ext_p = 1'b0;
      brk_p = 1'b0;
      check_status("timeout");
      send_frame(8'h32, 1'b0, 1'b0, -1, 1'b0, "after_to");

      // glitch rejection in idle and mid-frame
      idle_glitch();
      send_frame(8'h1C, 1'b0, 1'b0, 4, 1'b0, "glitch");

`ifdef PS2_SCANCODE_DECODE_EN
      send_frame(8'hF0, 1'b0, 1'b0, -1, 1'b0, "dec_f0");
      send_frame(8'h1C, 1'b0, 1'b0, -1, 1'b0, "dec_1c");
      send_frame(8'hE0, 1'b0, 1'b0, -1, 1'b0, "dec_e0a");
      send_frame(8'hF0, 1'b0, 1'b0, -1, 1'b0, "dec_f0b");
      send_frame(8'h75, 1'b0, 1'b0, -1, 1'b0, "dec_75a");
      send_frame(8'hE0, 1'b0, 1'b0, -1, 1'b0, "dec_e0c");
      send_frame(8'h75, 1'b0, 1'b0, -1, 1'b0, "dec_75c");
`endif

      // overflow: fill, drop one, then pop and push on the same edge
      drain_en = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         send_frame(8'(i), 1'b0, 1'b0, -1, 1'b0, "fill");
      end
      send_frame(8'h06, 1'b0, 1'b0, -1, 1'b1, "full_pop_push");
      drain_en = 1'b1;
      wait_drain("ovf");

      // reset mid-frame with entries queued
      drain_en = 1'b0;
      send_frame(8'h11, 1'b0, 1'b0, -1, 1'b0, "pre_rst_a");
      send_frame(8'h22, 1'b0, 1'b0, -1, 1'b0, "pre_rst_b");
      send_bits(mk_frame(8'h44, 1'b0, 1'b0), 5, -1);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      reset = 1'b0;
      exp_q.delete();
      ext_p = 1'b0;
      brk_p = 1'b0;
      @(negedge clk);
      chk("mid_rst_empty",   32'(empty),   32'd1);
      chk("mid_rst_count",   32'(count),   32'd0);
      chk("mid_rst_rd_data", 32'(rd_data), 32'd0);
      chk("mid_rst_rx_busy", 32'(rx_busy), 32'd0);
      drain_en = 1'b1;

      // randomized frames
      for (int i = 0; i < 24; i++) begin
         logic [7:0] b;
         int r;
         int g;
         r = int'($urandom % 8);
         b = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom);
         g = ($urandom % 4 == 0) ? int'($urandom_range(0, 10)) : -1;
         if ($urandom % 6 == 0) idle_glitch();
         send_frame(b, ($urandom % 8) == 0, ($urandom % 8) == 0, g, 1'b0, "rand");
      end
      wait_drain("final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected completion");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1);
   end

endmodule
